sb_rx_deserializer: RTL and testbench

SB_RX_DESERIALIZER -- requirements
Module: sb_rx_deserializer

---
 rtl/sb_rx_deserializer.sv | 76 +++++++
 tb/tb_sb_rx_deserializer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/sb_rx_deserializer.sv
// Sideband serial-to-parallel receiver: 64-bit MSB-first words on RXCKSB, handed to i_sb_clk via toggle sync.
// Optional sticky overrun flag is enabled by defining SB_RX_OVERRUN_DETECT_EN.
module sb_rx_deserializer (
  input  logic        i_sb_clk,
  input  logic        i_rst_n,
  input  logic        RXCKSB,
  input  logic        RXDATASB,
  input  logic        i_enable,
  input  logic        i_ready,
  output logic [63:0] o_data_out,
  output logic        o_valid
`ifdef SB_RX_OVERRUN_DETECT_EN
  ,
  output logic        o_overrun,
  input  logic        i_ovr_clr
`endif
);

  // ---------------- RXCKSB domain ----------------
  logic [63:0] shift_reg;
  logic [63:0] hold;
  logic [5:0]  bit_cnt;
  logic        tog;

  always_ff @(posedge RXCKSB or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_reg <= '0;
      hold      <= '0;
      bit_cnt   <= '0;
      tog       <= 1'b0;
    end else begin
      shift_reg <= {shift_reg[62:0], RXDATASB};
      bit_cnt   <= bit_cnt + 6'd1;
      if (bit_cnt == 6'd63) begin
        hold <= {shift_reg[62:0], RXDATASB};
        tog  <= ~tog;
      end
    end
  end

  // ---------------- i_sb_clk domain ----------------
  // Only the toggle is synchronized; hold is quasi-static for >=64 UI after it flips.
  logic [2:0] tog_sync;
  logic       detect;

  always_ff @(posedge i_sb_clk or negedge i_rst_n) begin
    if (!i_rst_n) tog_sync <= '0;
    else          tog_sync <= {tog_sync[1:0], tog};
  end

  assign detect = tog_sync[2] ^ tog_sync[1];

  always_ff @(posedge i_sb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data_out <= '0;
      o_valid    <= 1'b0;
    end else if (detect && i_enable) begin
      o_data_out <= hold;
      o_valid    <= 1'b1;
    end else if (i_ready && o_valid) begin
      o_valid    <= 1'b0;
    end
  end

`ifdef SB_RX_OVERRUN_DETECT_EN
  logic overwrite;
  assign overwrite = detect && i_enable && o_valid && !i_ready;

  always_ff @(posedge i_sb_clk or negedge i_rst_n) begin
    if (!i_rst_n)       o_overrun <= 1'b0;
    else if (overwrite) o_overrun <= 1'b1;
    else if (i_ovr_clr) o_overrun <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_sb_rx_deserializer.sv
// Scoreboard bench for sb_rx_deserializer: stimulus pushes expected words, a negedge monitor pops and compares.
// Serial clock runs at 8x the sideband clock (10 vs 80 time units) so packet timing is deterministic.
module tb_sb_rx_deserializer;

  logic        sb_clk;
  logic        rst_n;
  logic        rxck;
  logic        rxdata;
  logic        enable;
  logic        ready;
  logic [63:0] data_out;
  logic        valid;
`ifdef SB_RX_OVERRUN_DETECT_EN
  logic        overrun;
  logic        ovr_clr;
`endif

  int checks;
  int failures;

  typedef struct {
    logic [63:0] data;
    time         t;
  } exp_t;

  exp_t        sb_q[$];
  time         edge64_t;
  logic        prev_valid;
  logic [63:0] prev_data;

  localparam time LAT_MAX = 360;  // 4 sideband cycles plus half-cycle sampling offset

  sb_rx_deserializer dut (
    .i_sb_clk  (sb_clk),
    .i_rst_n   (rst_n),
    .RXCKSB    (rxck),
    .RXDATASB  (rxdata),
    .i_enable  (enable),
    .i_ready   (ready),
    .o_data_out(data_out),
    .o_valid   (valid)
`ifdef SB_RX_OVERRUN_DETECT_EN
    ,
    .o_overrun (overrun),
    .i_ovr_clr (ovr_clr)
`endif
  );

  initial begin
    sb_clk = 1'b0;
    forever #40 sb_clk = ~sb_clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [63:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      rxdata = w[63-i];
      #5 rxck = 1'b1;
      if (i == 63) edge64_t = $time;
      #5 rxck = 1'b0;
    end
  endtask

  task automatic send_word(input logic [63:0] w, input logic expect_out);
    send_bits(w, 64);
    if (expect_out) sb_q.push_back('{w, edge64_t});
  endtask

  // Start a packet a fixed offset after a sideband rising edge.
  task automatic align();
    @(posedge sb_clk);
    #8;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sb_clk);
  endtask

  task automatic accept();
    @(negedge sb_clk) ready = 1'b1;
    @(negedge sb_clk) ready = 1'b0;
  endtask

  // Monitor: a new presentation is o_valid rising or the word changing while valid.
  initial begin
    exp_t e;
    prev_valid = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge sb_clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
        prev_data  = '0;
      end else begin
        if (valid && (!prev_valid || data_out !== prev_data)) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%h required=none", data_out);
          end else begin
            e = sb_q.pop_front();
            chk("sb_word", data_out, e.data);
            checks++;
            if ($time - e.t > LAT_MAX) begin
              failures++;
              $display("FAIL latency actual=%0d required<=%0d", $time - e.t, LAT_MAX);
            end
          end
        end
        prev_valid = valid;
        prev_data  = data_out;
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    rxck     = 1'b0;
    rxdata   = 1'b0;
    enable   = 1'b1;
    ready    = 1'b0;
`ifdef SB_RX_OVERRUN_DETECT_EN
    ovr_clr  = 1'b0;
`endif

    // reset state
    wait_cyc(2);
    chk("rst_valid", 64'(valid), 64'h0);
    chk("rst_data", data_out, 64'h0);
`ifdef SB_RX_OVERRUN_DETECT_EN
    chk("rst_overrun", 64'(overrun), 64'h0);
`endif
    rst_n = 1'b1;
    wait_cyc(2);
    chk("rel_valid", 64'(valid), 64'h0);

    // disabled: word dropped
    enable = 1'b0;
    align();
    send_word(64'hDEAD_BEEF_0000_0001, 1'b0);
    wait_cyc(6);
    chk("dis_valid", 64'(valid), 64'h0);
    chk("dis_data", data_out, 64'h0);
    enable = 1'b1;

    // basic word, held while not ready
    align();
    send_word(64'hA5A5_0F0F_1234_8001, 1'b1);
    wait_cyc(8);
    chk("held_valid", 64'(valid), 64'h1);
    chk("held_data", data_out, 64'hA5A5_0F0F_1234_8001);

    // acceptance clears valid, keeps data
    accept();
    chk("acc_valid", 64'(valid), 64'h0);
    chk("acc_data", data_out, 64'hA5A5_0F0F_1234_8001);

    // two words, 32 UI gap, no consumer: newest wins
    align();
    send_word(64'h0000_0000_0000_0001, 1'b1);
    #320;
    send_word(64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    wait_cyc(6);
    chk("ovw_valid", 64'(valid), 64'h1);
    chk("ovw_data", data_out, 64'hFFFF_FFFF_FFFF_FFFE);
`ifdef SB_RX_OVERRUN_DETECT_EN
    chk("ovw_overrun", 64'(overrun), 64'h1);
    wait_cyc(2);
    chk("ovw_overrun_sticky", 64'(overrun), 64'h1);
    @(negedge sb_clk) ovr_clr = 1'b1;
    @(negedge sb_clk) ovr_clr = 1'b0;
    chk("ovr_clr", 64'(overrun), 64'h0);
`endif
    accept();
    chk("ovw_acc_valid", 64'(valid), 64'h0);

    // detection coincident with acceptance
    align();
    send_word(64'h0F1E_2D3C_4B5A_6978, 1'b1);
    wait_cyc(6);
    chk("coin_pre_valid", 64'(valid), 64'h1);
    align();
    send_word(64'h8877_6655_4433_2211, 1'b1);
    @(posedge sb_clk);
    @(posedge sb_clk);
    accept();  // ready high across the detection edge only
    chk("coin_valid", 64'(valid), 64'h1);
    chk("coin_data", data_out, 64'h8877_6655_4433_2211);
`ifdef SB_RX_OVERRUN_DETECT_EN
    chk("coin_overrun", 64'(overrun), 64'h0);
`endif
    accept();
    chk("coin_acc_valid", 64'(valid), 64'h0);

    // reset mid-packet discards the partial word
    align();
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 20);
    @(negedge sb_clk) rst_n = 1'b0;
    @(negedge sb_clk);
    chk("mid_rst_valid", 64'(valid), 64'h0);
    chk("mid_rst_data", data_out, 64'h0);
    rst_n = 1'b1;
    wait_cyc(3);
    chk("mid_rel_valid", 64'(valid), 64'h0);
    align();
    send_word(64'h0123_4567_89AB_CDEF, 1'b1);
    wait_cyc(6);
    chk("post_rst_valid", 64'(valid), 64'h1);
    chk("post_rst_data", data_out, 64'h0123_4567_89AB_CDEF);
    wait_cyc(4);

    chk("sb_q_empty", 64'(sb_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
